// File: rtl/alu_cmd_issuer.sv
// Command FIFO feeding a single-cycle ALU handshake: queue {op, mode, a, b}, issue in order, wait for alu_done.
// Optional watchdog on the WAIT state is enabled by defining ALU_CMD_TIMEOUT_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no command in flight; pops the FIFO head whenever count > 0
// WAIT  | command driven onto the ALU, outputs held until alu_done

module alu_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [2:0]               cmd_mode,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    output logic                     alu_enable,
    output logic                     alu_enable_a,
    output logic                     alu_enable_b,
    output logic [1:0]               alu_op,
    output logic [7:0]               alu_in_a,
    output logic [7:0]               alu_in_b,
    input  logic                     alu_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     timeout_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [20:0]   mem [DEPTH];
    logic [20:0]   head;
    logic [1:0]    head_op;
    logic [2:0]    head_mode;
    logic [7:0]    head_a;
    logic [7:0]    head_b;
    logic          push;
    logic          pop;

    // Full blocks a push even when a pop happens in the same cycle.
    assign cmd_ready = (count != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);

    assign head      = mem[rd_ptr];
    assign head_op   = head[20:19];
    assign head_mode = head[18:16];
    assign head_a    = head[15:8];
    assign head_b    = head[7:0];

    assign busy      = (state == WAIT);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_mode, cmd_a, cmd_b};
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef ALU_CMD_TIMEOUT_EN
    logic [3:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            alu_enable   <= 1'b0;
            alu_enable_a <= 1'b0;
            alu_enable_b <= 1'b0;
            alu_op       <= 2'b00;
            alu_in_a     <= 8'h00;
            alu_in_b     <= 8'h00;
            tmo_cnt      <= 4'd0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop && head_mode != 3'b000) begin
                        alu_op       <= head_op;
                        alu_in_a     <= head_a;
                        alu_in_b     <= head_b;
                        alu_enable   <= head_mode[0];
                        alu_enable_a <= head_mode[1];
                        alu_enable_b <= head_mode[2];
                        tmo_cnt      <= 4'd0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // Completion takes priority over an expiring watchdog.
                    if (alu_done) begin
                        alu_enable   <= 1'b0;
                        alu_enable_a <= 1'b0;
                        alu_enable_b <= 1'b0;
                        state        <= IDLE;
                    end else if (tmo_cnt == 4'hF) begin
                        alu_enable   <= 1'b0;
                        alu_enable_a <= 1'b0;
                        alu_enable_b <= 1'b0;
                        timeout_err  <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign timeout_err = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            alu_enable   <= 1'b0;
            alu_enable_a <= 1'b0;
            alu_enable_b <= 1'b0;
            alu_op       <= 2'b00;
            alu_in_a     <= 8'h00;
            alu_in_b     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop && head_mode != 3'b000) begin
                        alu_op       <= head_op;
                        alu_in_a     <= head_a;
                        alu_in_b     <= head_b;
                        alu_enable   <= head_mode[0];
                        alu_enable_a <= head_mode[1];
                        alu_enable_b <= head_mode[2];
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (alu_done) begin
                        alu_enable   <= 1'b0;
                        alu_enable_a <= 1'b0;
                        alu_enable_b <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule
